// File: rtl/sync_handshake_tx.sv
// sync_handshake_tx: source side of a toggle req/ack handshake that moves data words out of clk_source.
//   clk_source  in   source clock, all state on its rising edge
//   rst_dest    in   asynchronous active-low reset, shared with the destination so both toggles realign at 0
//   evt_valid   in   word offered
//   evt_data    in   word to send
//   evt_ready   out  block can accept (IDLE); transfer on evt_valid & evt_ready
//   req_toggle  out  flips once per accepted word, crosses to the destination
//   req_data    out  captured word, stable until the next accept
//   ack_toggle  in   asynchronous echo of req_toggle from the destination
//   busy        out  waiting for ack or in error
//   done_pulse  out  one-cycle strobe per acknowledged word
//   sent_cnt    out  acknowledged word count, wraps
//   timeout_err out  high while in the error state
//   err_clr     in   leave the error state
module sync_handshake_tx #(
  parameter int SYNC_STAGE = 3,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic              clk_source,
  input  logic              rst_dest,
  input  logic              evt_valid,
  input  logic [DATA_W-1:0] evt_data,
  output logic              evt_ready,
  output logic              req_toggle,
  output logic [DATA_W-1:0] req_data,
  input  logic              ack_toggle,
  output logic              busy,
  output logic              done_pulse,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic              timeout_err,
  input  logic              err_clr
);
  localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, ERR} state_t;
  state_t                r_state, w_next;
  logic [SYNC_STAGE-1:0] r_sync;
  logic [TW-1:0]         r_timer;
  logic                  r_req_toggle, r_done;
  logic [DATA_W-1:0]     r_req_data;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_ack_sync, w_match, w_expire, w_accept, w_ack_done, w_tmr_clr;
  assign w_ack_sync  = r_sync[SYNC_STAGE-1];
  // ack matches once the synchronised echo equals the toggle we last sent
  assign w_match     = w_ack_sync == r_req_toggle;
  assign w_expire    = (TIMEOUT != 0) && (r_timer == TLAST);
  assign evt_ready   = r_state == IDLE;
  assign busy        = !evt_ready;
  assign timeout_err = r_state == ERR;
  assign req_toggle  = r_req_toggle;
  assign req_data    = r_req_data;
  assign done_pulse  = r_done;
  assign sent_cnt    = r_cnt;
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_ack_done = 1'b0;
    w_tmr_clr  = 1'b0;
    case (r_state)
      IDLE: if (evt_valid) begin
        w_next   = WAIT_ACK;
        w_accept = 1'b1;
      end
      // ack is checked before the timer so a late-but-arrived ack never raises an error
      WAIT_ACK: if (w_match) begin
        w_next     = IDLE;
        w_ack_done = 1'b1;
      end else if (w_expire) w_next = ERR;
      ERR: if (err_clr) begin
        if (w_match) begin
          w_next     = IDLE;
          w_ack_done = 1'b1;
        end else begin
          w_next    = WAIT_ACK;
          w_tmr_clr = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_source or negedge rst_dest) begin
    if (!rst_dest) begin
      r_state      <= IDLE;
      r_sync       <= '0;
      r_timer      <= '0;
      r_req_toggle <= 1'b0;
      r_req_data   <= '0;
      r_done       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[SYNC_STAGE-2:0], ack_toggle};
      r_done  <= w_ack_done;
      if (w_ack_done) r_cnt <= r_cnt + CNT_W'(1);
      if (w_accept) begin
        r_req_data   <= evt_data;
        r_req_toggle <= ~r_req_toggle;
      end
      // with TIMEOUT==0 the timer never runs and stays at 0
      if (w_accept || w_tmr_clr) r_timer <= '0;
      else if (TIMEOUT != 0 && r_state == WAIT_ACK && !w_match && !w_expire) r_timer <= r_timer + TW'(1);
    end
  end
endmodule
